// File: rtl/mp_cond_subtractor.sv
// Limb-serial multi-precision conditional subtractor.
// Loads A and B least significant limb first, accumulating A - B with a
// rippling borrow, then emits R = (A >= B) ? A - B : A one limb per beat.
// Optional feature macro: MPSUB_UNCOND_EN adds an uncond input that forces
// the A - B result regardless of the final borrow.
//
// state | meaning
// LOAD  | accepting limb pairs, building d_mem/a_mem and the borrow chain
// EMIT  | presenting result limbs, advancing on each out_valid & out_ready

module mp_cond_subtractor #(
  parameter int LIMB_W    = 48,
  parameter int NUM_LIMBS = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] a_limb,
  input  logic [LIMB_W-1:0] b_limb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_limb,
  output logic              out_last,
`ifdef MPSUB_UNCOND_EN
  input  logic              uncond,
`endif
  output logic              a_ge_b
);

  localparam int KW = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_LIMBS - 1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic              borrow;
  logic              sel_a;
  logic [LIMB_W-1:0] a_mem [NUM_LIMBS];
  logic [LIMB_W-1:0] d_mem [NUM_LIMBS];
  logic [LIMB_W:0]   diff;
  logic              in_beat;
  logic              out_beat;
  logic              uncond_eff;

  assign in_beat  = in_valid & in_ready;
  assign out_beat = out_valid & out_ready;

  // One limb of the running subtraction; bit LIMB_W is the outgoing borrow.
  assign diff = {1'b0, a_limb} - {1'b0, b_limb} - {{LIMB_W{1'b0}}, borrow};

`ifdef MPSUB_UNCOND_EN
  logic uncond_q;
  // For a single-limb job the k = 0 beat is also the last one, so use the live input there.
  assign uncond_eff = (k == '0) ? uncond : uncond_q;
`else
  assign uncond_eff = 1'b0;
`endif

  // Capture each accepted limb of A and the matching partial difference.
  // Contents need no reset: they are only read after a full LOAD.
  always_ff @(posedge clk) begin
    if (in_beat) begin
      a_mem[k] <= a_limb;
      d_mem[k] <= diff[LIMB_W-1:0];
    end
  end

  // Sequencing FSM with registered handshake and comparison outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      k         <= '0;
      borrow    <= 1'b0;
      sel_a     <= 1'b0;
      a_ge_b    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef MPSUB_UNCOND_EN
      uncond_q  <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (in_beat) begin
            borrow <= diff[LIMB_W];
`ifdef MPSUB_UNCOND_EN
            if (k == '0) uncond_q <= uncond;
`endif
            if (k == K_LAST) begin
              sel_a     <= diff[LIMB_W] & ~uncond_eff;
              a_ge_b    <= ~diff[LIMB_W];
              k         <= '0;
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        EMIT: begin
          if (out_beat) begin
            if (k == K_LAST) begin
              state     <= LOAD;
              k         <= '0;
              borrow    <= 1'b0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Result limb is a plain mux of stored registers; zero when idle.
  assign out_limb = !out_valid ? '0 : (sel_a ? a_mem[k] : d_mem[k]);
  assign out_last = out_valid & (k == K_LAST);

endmodule

// File: tb/tb_mp_cond_subtractor.sv
// Scoreboard bench for mp_cond_subtractor (LIMB_W = 48, NUM_LIMBS = 4).
// Expected limbs come from whole-operand arithmetic on 192-bit values.

module tb_mp_cond_subtractor;

  localparam int LW = 48;
  localparam int NL = 4;
  localparam int OW = LW * NL;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] a_limb;
  logic [LW-1:0] b_limb;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_limb;
  logic          out_last;
  logic          a_ge_b;
  logic          uncond;

  mp_cond_subtractor #(.LIMB_W(LW), .NUM_LIMBS(NL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_limb    (a_limb),
    .b_limb    (b_limb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_limb  (out_limb),
    .out_last  (out_last),
`ifdef MPSUB_UNCOND_EN
    .uncond    (uncond),
`endif
    .a_ge_b    (a_ge_b)
  );

  typedef struct {
    logic [LW-1:0] limb;
    logic          last;
    logic          ge;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_ge;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output beat and checks stall stability.
  logic          held_v = 1'b0;
  logic [LW-1:0] held_limb;
  logic          held_last;
  logic          held_ge;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      exp_t e;
      check("in_ready_in_emit", in_ready, 0);
      if (held_v) begin
        check("stall_limb", out_limb, held_limb);
        check("stall_last", out_last, held_last);
        check("stall_ge", a_ge_b, held_ge);
      end
      if (out_ready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_limb, 64'hDEAD_0000_0000_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("out_limb", out_limb, e.limb);
          check("out_last", out_last, e.last);
          check("a_ge_b", a_ge_b, e.ge);
        end
      end else begin
        held_v    = 1'b1;
        held_limb = out_limb;
        held_last = out_last;
        held_ge   = a_ge_b;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // mode 0: out_ready held high; 1: random out_ready; 2: three-cycle stall after first beat.
  // Garbage in_valid is driven throughout EMIT and must be ignored.
  task automatic drain(input int mode);
    int c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(c >= 1 && c <= 3);
      endcase
      in_valid = $urandom_range(0, 1);
      a_limb   = {$urandom, $urandom} & {LW{1'b1}};
      b_limb   = {$urandom, $urandom} & {LW{1'b1}};
      @(posedge clk); #1;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("drain_remaining", exp_q.size(), 0);
    check("in_ready_after_job", in_ready, 1);
    check("out_valid_after_job", out_valid, 0);
  endtask

  task automatic send_job(input logic [OW-1:0] a, input logic [OW-1:0] b,
                          input bit unc, input bit gaps, input int mode);
    logic [OW-1:0] r;
    bit ge;
    ge = (a >= b);
    r  = (ge || unc) ? a - b : a;
    check("a_ge_b_hold", a_ge_b, prev_ge);
    for (int i = 0; i < NL; i++)
      exp_q.push_back('{limb: r[i*LW +: LW], last: (i == NL-1), ge: ge});
    for (int i = 0; i < NL; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      check("in_ready_load", in_ready, 1);
      check("out_valid_load", out_valid, 0);
      in_valid = 1'b1;
      uncond   = unc;
      a_limb   = a[i*LW +: LW];
      b_limb   = b[i*LW +: LW];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    uncond   = 1'b0;
    check("latency_out_valid", out_valid, 1);
    drain(mode);
    prev_ge = ge;
  endtask

  function automatic logic [OW-1:0] rand_op();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [OW-1:0] a, b;
    logic [OW-1:0] rep;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    uncond    = 1'b0;
    a_limb    = '0;
    b_limb    = '0;
    prev_ge   = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_limb", out_limb, 0);
    check("rst_out_last", out_last, 0);
    check("rst_a_ge_b", a_ge_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    send_job(192'd5, 192'd3, 1'b0, 1'b0, 0);
    a = '0; a[LW] = 1'b1;
    send_job(a, 192'd1, 1'b0, 1'b0, 0);
    rep = {NL{48'h1234_5678_9ABC}};
    send_job(rep, rep, 1'b0, 1'b0, 0);
    send_job(192'd2, 192'd7, 1'b0, 1'b0, 0);
    a = rand_op(); b = rand_op();
    send_job(a, b, 1'b0, 1'b1, 2);
    send_job(a, b, 1'b0, 1'b0, 0);

    // Abort a half-loaded job with reset, then run a clean one.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_limb   = 48'hFFFF_0000_FFFF;
      b_limb   = 48'hFFFF_FFFF_FFFF;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_a_ge_b", a_ge_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    prev_ge = 1'b0;
    @(posedge clk); #1;
    send_job(192'd9, 192'd4, 1'b0, 1'b0, 0);

`ifdef MPSUB_UNCOND_EN
    send_job(192'd2, 192'd7, 1'b1, 1'b0, 0);
`endif

    for (int j = 0; j < 30; j++) begin
      a = rand_op();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = rand_op();
        2:       b = a + OW'($urandom_range(1, 3));
        default: b = a - OW'($urandom_range(0, 3));
      endcase
      send_job(a, b, 1'b0, $urandom_range(0, 1), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget, got %0d errors so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mp_cond_subtractor.md
# mp_cond_subtractor

Limb-serial multi-precision conditional subtractor for the modular-arithmetic datapath. Used after Montgomery reduction and modular addition to bring a result back into range. The block accepts an operand pair A, B as NUM_LIMBS limbs of LIMB_W bits, least significant limb first. It then emits the same number of limbs of R = (A ≥ B) ? A − B : A, plus a comparison flag. It is the subtract-side counterpart of the 48-bit DSP adder and uses the same 48-bit limb width by default.

## Interface
Parameters:
- LIMB_W, 48, limb width in bits
- NUM_LIMBS, 22, limbs per operand, at least 1; operand width = LIMB_W·NUM_LIMBS

Ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input limb pair valid
- in_ready  out  1  block can accept a limb pair
- a_limb  in  LIMB_W  limb of A (minuend)
- b_limb  in  LIMB_W  limb of B (subtrahend, typically the modulus)
- out_valid  out  1  result limb valid
- out_ready  in  1  downstream accepts the result limb
- out_limb  out  LIMB_W  limb of R, least significant limb first
- out_last  out  1  marks the final (most significant) result limb
- a_ge_b  out  1  1 when A ≥ B; valid and stable while out_valid is high
- uncond  in  1  present only with MPSUB_UNCOND_EN (see Configuration)

## Operation
- Two states: LOAD and EMIT. Reset puts the block in LOAD.
- LOAD:
  - in_ready = 1.
  - On each in_valid & in_ready beat, with limb index k from 0 to NUM_LIMBS−1:
    - d = {0,a_limb} − {0,b_limb} − borrow.
    - Store a_limb in a_mem[k] and d[LIMB_W−1:0] in d_mem[k].
    - borrow ← d[LIMB_W].
    - k increments.
  - borrow is 0 at the start of each job.
- After the beat with k = NUM_LIMBS−1:
  - sel_a ← final borrow.
  - a_ge_b ← ~final borrow.
  - k ← 0, and the state moves to EMIT.
- EMIT:
  - in_ready = 0, out_valid = 1.
  - out_limb = sel_a ? a_mem[k] : d_mem[k].
  - out_last = (k == NUM_LIMBS−1).
  - Each out_valid & out_ready beat increments k.
  - The beat with out_last set returns the block to LOAD and clears borrow and k.
- Arithmetic is modulo 2^(LIMB_W·NUM_LIMBS). Operands are unsigned. There is no sign extension.
- Storage is register arrays, 2·NUM_LIMBS·LIMB_W bits. out_limb is a mux of stored registers, so there is no read latency.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_limb = 0, out_last = 0, a_ge_b = 0.
  - State is LOAD; k, borrow and sel_a are 0.
- Latency: if the last input beat is at cycle T, out_valid rises at cycle T+1.
- Input throughput: one limb per cycle while in_valid is held.
- Output throughput: one limb per cycle while out_ready is held.
- Minimum job period: 2·NUM_LIMBS cycles. LOAD and EMIT do not overlap.
- Input gaps (in_valid low) during LOAD pause the accumulation. The partial job and borrow are kept.
- When out_ready is low during EMIT, out_limb, out_last and a_ge_b hold stable.
- in_valid during EMIT is ignored (in_ready = 0). Nothing is stored.
- After the final output beat at cycle U, in_ready = 1 at U+1.
- a_ge_b holds its value from the last job until the next job completes LOAD.
- Asserting rst at any point aborts the job immediately and restores all reset values. A partially loaded or partially emitted job is discarded.
- Boundary cases:
  - A == B gives R = 0 and a_ge_b = 1.
  - A < B gives R = A and a_ge_b = 0.
  - NUM_LIMBS = 1 gives a single-beat load and a single-beat emit with out_last = 1.

## Configuration
- MPSUB_UNCOND_EN defined:
  - Adds the uncond port.
  - uncond is sampled on the k = 0 input beat. When it was 1, sel_a is forced to 0 and R = A − B mod 2^(LIMB_W·NUM_LIMBS) is emitted regardless of borrow.
  - a_ge_b still reports ~final borrow.
- MPSUB_UNCOND_EN undefined:
  - No uncond port.
  - Selection is always conditional, as described under Operation.

## Test plan
All scenarios use LIMB_W = 48 and NUM_LIMBS = 4 unless stated.
- A = 0x…0005 (limb0 = 5, others 0), B = 3 → out limbs 2, 0, 0, 0; a_ge_b = 1; out_last on the 4th beat; out_valid one cycle after the 4th input beat.
- Borrow chain: A limbs {0, 1, 0, 0}, B limbs {1, 0, 0, 0} → R limbs {0xFFFFFFFFFFFF, 0, 0, 0}; a_ge_b = 1.
- A = B = all limbs 0x123456789ABC → R all zero; a_ge_b = 1.
- A = 2, B = 7 → R = A exactly (limbs 2, 0, 0, 0); a_ge_b = 0.
- Backpressure and gaps:
  - Insert random in_valid gaps and hold out_ready low for 3 cycles mid-EMIT.
  - Expect results identical to the no-stall run and out_limb stable during the stall.
  - No input accepted during EMIT.
- rst pulse after 2 input beats, then a fresh A = 9, B = 4 job → R = 5. No residue of the aborted job.
- With MPSUB_UNCOND_EN defined: A = 2, B = 7, uncond = 1 → R = 2^192 − 5, a_ge_b = 0.
